// File: rtl/spi_cmd_sequencer_if.sv
// rtl/spi_cmd_sequencer_if.sv - command, response and spi_master side signals of the sequencer
interface spi_cmd_sequencer_if #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic                     cmd_rd_we;
    logic [ADDRESS_WIDTH-1:0] cmd_address;
    logic [DATA_WIDTH-1:0]    cmd_data;

    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_data;
    logic                     rsp_error;

    logic                     spi_enable;
    logic                     spi_rd_we;
    logic [ADDRESS_WIDTH-1:0] spi_address;
    logic [DATA_WIDTH-1:0]    spi_data;
    logic                     spi_busy;
    logic [DATA_WIDTH-1:0]    spi_data_read;
    logic                     spi_data_read_valid;

    modport slave (
        input  cmd_valid, cmd_rd_we, cmd_address, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_data, rsp_error,
        input  rsp_ready,
        output spi_enable, spi_rd_we, spi_address, spi_data,
        input  spi_busy, spi_data_read, spi_data_read_valid
    );

    modport master (
        output cmd_valid, cmd_rd_we, cmd_address, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_data, rsp_error,
        output rsp_ready,
        input  spi_enable, spi_rd_we, spi_address, spi_data,
        output spi_busy, spi_data_read, spi_data_read_valid
    );
endinterface

// File: rtl/spi_cmd_sequencer.sv
// rtl/spi_cmd_sequencer.sv - queued command front-end issuing single-cycle enables to spi_master
module spi_cmd_sequencer #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int CMD_DEPTH     = 4,
    parameter int START_TIMEOUT = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    spi_cmd_sequencer_if.slave           bus,
    output logic [$clog2(CMD_DEPTH):0]   cmd_count,
    output logic                         fault,
    output logic                         idle
);
    localparam int PW = $clog2(CMD_DEPTH);
    localparam int TW = $clog2(START_TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(START_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_LAUNCH     = 3'd1;
    localparam logic [2:0] S_WAIT_START = 3'd2;
    localparam logic [2:0] S_WAIT_DONE  = 3'd3;
    localparam logic [2:0] S_FINISH     = 3'd4;

    logic                     mem_we_q   [CMD_DEPTH];
    logic [ADDRESS_WIDTH-1:0] mem_addr_q [CMD_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_data_q [CMD_DEPTH];

    logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
    logic [PW:0]              count_q;
    logic [2:0]               state_q, state_d;
    logic [TW-1:0]            tcnt_q;
    logic                     timeout_q;
    logic                     cap_flag_q;
    logic [DATA_WIDTH-1:0]    cap_data_q;
    logic                     spi_rd_we_q;
    logic [ADDRESS_WIDTH-1:0] spi_address_q;
    logic [DATA_WIDTH-1:0]    spi_data_q;
    logic                     rsp_valid_q;
    logic [DATA_WIDTH-1:0]    rsp_data_q;
    logic                     rsp_error_q;
    logic                     fault_q;

    logic cmd_ready_w, push, launch, head_we, in_wait, start_expired;

    assign cmd_ready_w   = (count_q < (PW+1)'(CMD_DEPTH));
    assign push          = bus.cmd_valid && cmd_ready_w;
    assign head_we       = mem_we_q[rd_ptr_q];
    // A read may only launch once the previous response has been consumed.
    assign launch        = (state_q == S_IDLE) && (count_q != '0) && !bus.spi_busy &&
                           (head_we || !rsp_valid_q);
    assign in_wait       = (state_q == S_WAIT_START) || (state_q == S_WAIT_DONE);
    assign start_expired = (state_q == S_WAIT_START) && !bus.spi_busy && (tcnt_q == TLAST);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (launch) state_d = S_LAUNCH;
            S_LAUNCH:     state_d = S_WAIT_START;
            S_WAIT_START: begin
                if (bus.spi_busy)       state_d = S_WAIT_DONE;
                else if (start_expired) state_d = S_FINISH;
            end
            S_WAIT_DONE:  if (!bus.spi_busy) state_d = S_FINISH;
            S_FINISH:     state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem_we_q[wr_ptr_q]   <= bus.cmd_rd_we;
            mem_addr_q[wr_ptr_q] <= bus.cmd_address;
            mem_data_q[wr_ptr_q] <= bus.cmd_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            state_q       <= S_IDLE;
            tcnt_q        <= '0;
            timeout_q     <= 1'b0;
            cap_flag_q    <= 1'b0;
            cap_data_q    <= '0;
            spi_rd_we_q   <= 1'b0;
            spi_address_q <= '0;
            spi_data_q    <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_error_q   <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
            if (launch) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, launch})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            if (launch) begin
                spi_rd_we_q   <= head_we;
                spi_address_q <= mem_addr_q[rd_ptr_q];
                spi_data_q    <= mem_data_q[rd_ptr_q];
                cap_flag_q    <= 1'b0;
                cap_data_q    <= '0;
                tcnt_q        <= '0;
                timeout_q     <= 1'b0;
            end

            if (state_q == S_WAIT_START && !bus.spi_busy && !start_expired)
                tcnt_q <= tcnt_q + 1'b1;
            if (start_expired) begin
                fault_q   <= 1'b1;
                timeout_q <= 1'b1;
            end

            if (in_wait && bus.spi_data_read_valid) begin
                cap_data_q <= bus.spi_data_read;
                cap_flag_q <= 1'b1;
            end

            if (rsp_valid_q && bus.rsp_ready)
                rsp_valid_q <= 1'b0;
            if (state_q == S_FINISH && !spi_rd_we_q) begin
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= cap_flag_q ? cap_data_q : '0;
                rsp_error_q <= timeout_q | ~cap_flag_q;
            end
        end
    end

    assign bus.cmd_ready   = cmd_ready_w;
    assign bus.spi_enable  = (state_q == S_LAUNCH);
    assign bus.spi_rd_we   = spi_rd_we_q;
    assign bus.spi_address = spi_address_q;
    assign bus.spi_data    = spi_data_q;
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_data    = rsp_data_q;
    assign bus.rsp_error   = rsp_error_q;

    assign cmd_count = count_q;
    assign fault     = fault_q;
    assign idle      = (state_q == S_IDLE) && (count_q == '0) && !rsp_valid_q;
endmodule

// File: doc/spi_cmd_sequencer.md
Name: spi_cmd_sequencer

Overview:
- Command front-end sitting directly upstream of spi_master.
- Accepts write/read requests over a valid/ready interface and buffers them in a small FIFO.
- Issues each request to spi_master as a single-cycle enable pulse with stable operands, and tracks the master's busy window.
- Returns read data (with an error flag) over a valid/ready response port.

Parameters:
- DATA_WIDTH, 32, width of data words.
- ADDRESS_WIDTH, 32, width of addresses.
- CMD_DEPTH, 4, command FIFO entries; power of 2, ≥2.
- START_TIMEOUT, 16, cycles to wait for spi_busy to rise after enable.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept.
- cmd_rd_we  in  1  1=write, 0=read.
- cmd_address  in  ADDRESS_WIDTH  target address.
- cmd_data  in  DATA_WIDTH  write data (ignored for reads).
- rsp_valid  out  1  read response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  read data.
- rsp_error  out  1  read failed (timeout or no data_read_valid).
- spi_enable  out  1  to spi_master enable.
- spi_rd_we  out  1  to spi_master rd_we.
- spi_address  out  ADDRESS_WIDTH  to spi_master address.
- spi_data  out  DATA_WIDTH  to spi_master data.
- spi_busy  in  1  from spi_master busy.
- spi_data_read  in  DATA_WIDTH  from spi_master data_read.
- spi_data_read_valid  in  1  from spi_master data_read_valid.
- cmd_count  out  $clog2(CMD_DEPTH)+1  FIFO occupancy.
- fault  out  1  sticky: any start timeout occurred.
- idle  out  1  state IDLE, FIFO empty, rsp_valid=0.

Behaviour:
- Reset (synchronous, edge with reset=1):
  - FIFO emptied; cmd_count=0; state=IDLE.
  - spi_enable=0; spi_rd_we=0; spi_address=0; spi_data=0.
  - rsp_valid=0; rsp_data=0; rsp_error=0; fault=0.
  - Reset mid-transaction abandons it with no response. spi_master is not reset by this block, so IDLE still waits for spi_busy=0.
- FIFO:
  - Push on cmd_valid&cmd_ready.
  - cmd_ready = (cmd_count<CMD_DEPTH); it is independent of a same-cycle pop, so a full FIFO rejects even while popping.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo CMD_DEPTH.
- FSM states: IDLE, LAUNCH, WAIT_START, WAIT_DONE, FINISH.
- IDLE -> LAUNCH when FIFO non-empty, spi_busy=0, and (head is write OR rsp_valid=0). On this edge:
  - pop head;
  - register head into spi_rd_we/spi_address/spi_data;
  - clear capture flag and timeout counter.
- spi_* operands stay stable until the next IDLE->LAUNCH.
- LAUNCH: spi_enable=1 for exactly this one cycle; next state WAIT_START.
- Latency: command accepted at edge k into an empty FIFO while IDLE/idle master gives LAUNCH at edge k+1, so spi_enable is high between edges k+1 and k+2.
- WAIT_START:
  - spi_busy=1 -> WAIT_DONE.
  - Otherwise increment counter. After START_TIMEOUT cycles without busy: fault<=1, mark timeout, go to FINISH.
- WAIT_DONE:
  - spi_busy=0 -> FINISH.
  - No timeout in this state.
- Capture rule (WAIT_START and WAIT_DONE, including the cycle busy falls): spi_data_read_valid=1 latches spi_data_read and sets the capture flag. The last capture wins.
- FINISH:
  - Read: load rsp_data = captured data (0 if none) and rsp_error = timeout | !captured; set rsp_valid=1.
  - Write: no response.
  - Next state IDLE.
- Response register:
  - rsp_valid clears on rsp_valid&rsp_ready.
  - rsp_data and rsp_error hold while rsp_valid=1 and rsp_ready=0.
  - A read cannot launch while rsp_valid=1, so a response is never overwritten.
  - Writes may launch while a response is pending.
- cmd_count and idle are combinational from registered state.

Test Plan:
- Write A5A5A5A5 @0x10, master divider=2 -> spi_enable one-cycle pulse 2 cycles after accept; spi_data=A5A5A5A5, spi_rd_we=1 held through busy; no rsp_valid; idle=1 afterward.
- Read @0x10 with slave returning 0x12345678 -> one rsp_valid with rsp_data=0x12345678, rsp_error=0.
- Push 5 commands back-to-back with the master busy -> cmd_ready=0 after 4th (cmd_count=4); 5th accepted only after first pop; enables issued in FIFO order.
- Read pending with rsp_ready=0, then queued read+write -> write launches, second read stalls until rsp handshake; rsp_data stable while stalled.
- Master disconnected (busy stuck 0) -> after 16 cycles fault=1; read response rsp_error=1, rsp_data=0.
- Assert reset during WAIT_DONE with 2 commands queued -> next edge: cmd_count=0, spi_enable=0, rsp_valid=0; no new launch until spi_busy=0.
